sim_bench: RTL and testbench

SIM_BENCH -- requirements
Module: sim_bench

---
 rtl/sim_bench.sv | 226 ++++++++++++++++++++++
 tb/tb_sim_bench.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_bench.sv
// Self-contained SPI loop: mode-0 controller, synchronised peripheral with RX/TX echo FIFOs, and a checker.
// Option: define SIM_BENCH_IRQ_EN to drive peripheral_irq from RX FIFO non-empty.
module sim_bench (
   input  logic        refclk,
   input  logic        rst,
   output logic        com_sclk,
   output logic        com_copi,
   input  logic        com_cipo,
   output logic        com_csn,
   input  logic        com_hold,
   input  logic        peripheral_sclk,
   input  logic        peripheral_copi,
   output logic        peripheral_cipo,
   input  logic        peripheral_csn,
   output logic        peripheral_hold,
   output logic        peripheral_irq,
   output logic        sim_success,
   output logic        sim_done,
   output logic [31:0] sim_report
);

   typedef enum logic [2:0] {S_GAP, S_LEAD, S_SHIFT, S_TAIL, S_FIN, S_DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  bits;
   logic [3:0]  fidx;
   logic [15:0] word, exp_word, c_sr, c_rx, last_word, frame_word;
   logic [7:0]  errors, frames;
   logic        done;

   function automatic logic [15:0] rotl1(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Frame 8 carries an all-zero flush word so the last echoed word comes back.
   assign frame_word = (fidx == 4'd8) ? 16'h0000 : word;

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state     <= S_GAP;
         cnt       <= '0;
         bits      <= '0;
         fidx      <= '0;
         word      <= 16'hA503;
         exp_word  <= '0;
         c_sr      <= '0;
         c_rx      <= '0;
         last_word <= '0;
         errors    <= '0;
         frames    <= '0;
         done      <= 1'b0;
         com_csn   <= 1'b1;
         com_sclk  <= 1'b0;
         com_copi  <= 1'b0;
      end else begin
         case (state)
            S_GAP: begin
               if (cnt == 4'd15 && !com_hold) begin
                  com_csn  <= 1'b0;
                  com_copi <= frame_word[15];
                  c_sr     <= frame_word;
                  cnt      <= '0;
                  state    <= S_LEAD;
               end else if (cnt != 4'd15) begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_LEAD: begin
               if (cnt == 4'd7) begin
                  com_sclk <= 1'b1;
                  c_rx     <= {c_rx[14:0], com_cipo};
                  cnt      <= '0;
                  bits     <= '0;
                  state    <= S_SHIFT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_SHIFT: begin
               if (cnt == 4'd7) begin
                  cnt <= '0;
                  if (com_sclk) begin
                     com_sclk <= 1'b0;
                     if (bits == 4'd15) begin
                        com_copi <= 1'b0;
                        state    <= S_TAIL;
                     end else begin
                        com_copi <= c_sr[14];
                        c_sr     <= {c_sr[14:0], 1'b0};
                        bits     <= bits + 4'd1;
                     end
                  end else begin
                     com_sclk <= 1'b1;
                     c_rx     <= {c_rx[14:0], com_cipo};
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_TAIL: begin
               if (cnt == 4'd7) begin
                  com_csn   <= 1'b1;
                  cnt       <= '0;
                  last_word <= c_rx;
                  if (c_rx != exp_word) errors <= sat_inc(errors);
                  frames    <= frames + 8'd1;
                  exp_word  <= word;
                  word      <= rotl1(word);
                  fidx      <= fidx + 4'd1;
                  state     <= (fidx == 4'd8) ? S_FIN : S_GAP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_FIN: begin
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: ;
            default: state <= S_GAP;
         endcase
      end
   end

   assign sim_done    = done;
   assign sim_success = done && (errors == 8'd0);
   assign sim_report  = {last_word, errors, frames};

   // Peripheral: inputs are asynchronous to refclk, so all decisions use 2-flop copies.
   logic [1:0]  sclk_s, copi_s, csn_s;
   logic        sclk_d, csn_d, cipo_r, hold_r;
   logic [4:0]  bitc;
   logic [15:0] p_rx, p_tx, tx_head;
   logic [15:0] rx_mem [8];
   logic [15:0] tx_mem [8];
   logic [2:0]  rx_wr, rx_rd, tx_wr, tx_rd;
   logic [3:0]  rx_cnt, tx_cnt;
   logic        sclk_rise, sclk_fall, csn_fall, csn_rise, rx_push, echo, tx_pop;

   assign sclk_rise = sclk_s[1] & ~sclk_d;
   assign sclk_fall = ~sclk_s[1] & sclk_d;
   assign csn_fall  = ~csn_s[1] & csn_d;
   assign csn_rise  = csn_s[1] & ~csn_d;
   assign rx_push   = csn_rise && (bitc == 5'd16) && (rx_cnt != 4'd8);
   assign echo      = (rx_cnt != 4'd0) && (tx_cnt != 4'd8);
   assign tx_pop    = csn_fall && (tx_cnt != 4'd0);
   assign tx_head   = (tx_cnt == 4'd0) ? 16'h0000 : tx_mem[tx_rd];

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         sclk_s <= '0;
         copi_s <= '0;
         csn_s  <= 2'b11;
         sclk_d <= 1'b0;
         csn_d  <= 1'b1;
         bitc   <= '0;
         cipo_r <= 1'b0;
         p_rx   <= '0;
         p_tx   <= '0;
         rx_wr  <= '0;
         rx_rd  <= '0;
         tx_wr  <= '0;
         tx_rd  <= '0;
         rx_cnt <= '0;
         tx_cnt <= '0;
         hold_r <= 1'b0;
      end else begin
         sclk_s <= {sclk_s[0], peripheral_sclk};
         copi_s <= {copi_s[0], peripheral_copi};
         csn_s  <= {csn_s[0], peripheral_csn};
         sclk_d <= sclk_s[1];
         csn_d  <= csn_s[1];
         if (csn_fall) begin
            p_tx   <= tx_head;
            cipo_r <= tx_head[15];
            bitc   <= '0;
         end else if (csn_rise) begin
            cipo_r <= 1'b0;
         end else if (!csn_s[1]) begin
            if (sclk_rise) begin
               p_rx <= {p_rx[14:0], copi_s[1]};
               if (bitc != 5'd31) bitc <= bitc + 5'd1;
            end
            if (sclk_fall) begin
               cipo_r <= p_tx[14];
               p_tx   <= {p_tx[14:0], 1'b0};
            end
         end
         if (rx_push) rx_wr <= rx_wr + 3'd1;
         if (echo) begin
            rx_rd <= rx_rd + 3'd1;
            tx_wr <= tx_wr + 3'd1;
         end
         if (tx_pop) tx_rd <= tx_rd + 3'd1;
         rx_cnt <= rx_cnt + {3'b000, rx_push} - {3'b000, echo};
         tx_cnt <= tx_cnt + {3'b000, echo} - {3'b000, tx_pop};
         hold_r <= (rx_cnt == 4'd8);
      end
   end

   always_ff @(posedge refclk) begin
      if (rx_push) rx_mem[rx_wr] <= p_rx;
      if (echo)    tx_mem[tx_wr] <= rx_mem[rx_rd];
   end

   // Gate with the raw select so cipo is quiet for the whole time csn is high.
   assign peripheral_cipo = cipo_r & ~peripheral_csn;
   assign peripheral_hold = hold_r;

`ifdef SIM_BENCH_IRQ_EN
   logic irq_r;
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) irq_r <= 1'b0;
      else      irq_r <= (rx_cnt != 4'd0);
   end
   assign peripheral_irq = irq_r;
`else
   assign peripheral_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sim_bench.sv
// Bench for sim_bench: controller wired to peripheral, frame scoreboard on the SPI lines, run-level checks.
module tb_sim_bench;

   logic        refclk = 1'b0;
   logic        rst = 1'b0;
   logic        com_sclk, com_copi, com_cipo, com_csn, com_hold;
   logic        peripheral_cipo, peripheral_hold, peripheral_irq;
   logic        sim_success, sim_done;
   logic [31:0] sim_report;
   logic        force_cipo = 1'b0;
   logic        force_hold = 1'b0;

   assign com_cipo = force_cipo ? 1'b1 : peripheral_cipo;
   assign com_hold = peripheral_hold | force_hold;

   always #5 refclk = ~refclk;

   sim_bench dut (
      .refclk          (refclk),
      .rst             (rst),
      .com_sclk        (com_sclk),
      .com_copi        (com_copi),
      .com_cipo        (com_cipo),
      .com_csn         (com_csn),
      .com_hold        (com_hold),
      .peripheral_sclk (com_sclk),
      .peripheral_copi (com_copi),
      .peripheral_cipo (peripheral_cipo),
      .peripheral_csn  (com_csn),
      .peripheral_hold (peripheral_hold),
      .peripheral_irq  (peripheral_irq),
      .sim_success     (sim_success),
      .sim_done        (sim_done),
      .sim_report      (sim_report)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

   // Scoreboard: expected words queued at csn fall, compared at csn rise.
   logic [15:0] q_copi [$];
   logic [15:0] q_cipo [$];
   logic        prev_csn = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, irq_seen = 1'b0;
   logic [15:0] sh_copi = '0, sh_cipo = '0, mw = 16'hA503, mexp = '0, ec, ei;
   int          cyc = 0, t_fall = 0, t_lastfall = 0, t_rise = -1000, nrise = 0, mk = 0;
   int          csn_low = 0;

   always @(negedge refclk) begin
      cyc++;
      if (!rst) begin
         in_frame = 1'b0;
         mk = 0;
         mw = 16'hA503;
         mexp = '0;
         q_copi.delete();
         q_cipo.delete();
         t_rise = -1000;
         prev_csn = 1'b1;
         prev_sclk = 1'b0;
      end else begin
         if (!com_csn) csn_low++;
         if (peripheral_irq) irq_seen = 1'b1;
         if (prev_csn && !com_csn) begin
            check("gap_ge16", 32'(cyc - t_rise >= 16), 32'd1);
            q_copi.push_back((mk == 8) ? 16'h0000 : mw);
            q_cipo.push_back(force_cipo ? 16'hFFFF : mexp);
            mexp = mw;
            mw = rotl(mw);
            mk++;
            in_frame = 1'b1;
            t_fall = cyc;
            nrise = 0;
         end
         if (in_frame && !prev_sclk && com_sclk) begin
            if (nrise == 0) check("lead_cycles", 32'(cyc - t_fall), 32'd8);
            sh_copi = {sh_copi[14:0], com_copi};
            sh_cipo = {sh_cipo[14:0], com_cipo};
            nrise++;
         end
         if (in_frame && prev_sclk && !com_sclk) t_lastfall = cyc;
         if (in_frame && !prev_csn && com_csn) begin
            in_frame = 1'b0;
            t_rise = cyc;
            if (q_copi.size() == 0) begin
               check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
               ec = q_copi.pop_front();
               ei = q_cipo.pop_front();
               check($sformatf("copi_f%0d", mk - 1), {16'h0, sh_copi}, {16'h0, ec});
               check($sformatf("cipo_f%0d", mk - 1), {16'h0, sh_cipo}, {16'h0, ei});
               check("bits_per_frame", 32'(nrise), 32'd16);
               check("tail_cycles", 32'(cyc - t_lastfall), 32'd8);
            end
         end
         prev_csn = com_csn;
         prev_sclk = com_sclk;
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_outs"}, {24'h0, com_csn, com_sclk, com_copi, peripheral_cipo,
                             peripheral_hold, peripheral_irq, sim_done, sim_success}, 32'h80);
      check({tag, "_report"}, sim_report, 32'h0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!sim_done && n < 5000) begin
         @(negedge refclk);
         n++;
      end
      if (!sim_done) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_frames(input string tag, input int k);
      int n = 0;
      while (int'(sim_report[7:0]) < k && n < 5000) begin
         @(negedge refclk);
         n++;
      end
      if (int'(sim_report[7:0]) < k) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic restart();
      @(negedge refclk);
      rst = 1'b0;
      repeat (3) @(negedge refclk);
      check_reset("reset");
      rst = 1'b1;
   endtask

   logic [15:0] w7;
   int          snap;

   initial begin
      w7 = 16'hA503;
      for (int i = 0; i < 7; i++) w7 = rotl(w7);

      // Normal run
      repeat (3) @(negedge refclk);
      check_reset("por");
      rst = 1'b1;
      wait_done("run1");
      check("run1_success", {31'h0, sim_success}, 32'd1);
      check("run1_report", sim_report, {w7, 8'h00, 8'h09});
      repeat (50) @(negedge refclk);
      check("idle_lines", {29'h0, com_csn, com_sclk, com_copi}, 32'd4);
      check("done_sticky", {31'h0, sim_done}, 32'd1);
`ifdef SIM_BENCH_IRQ_EN
      check("irq_seen", {31'h0, irq_seen}, 32'd1);
`else
      check("irq_tied", {31'h0, irq_seen}, 32'd0);
`endif

      // cipo stuck high: every frame mismatches
      force_cipo = 1'b1;
      restart();
      wait_done("run2");
      check("stuck_errs", {24'h0, sim_report[15:8]}, 32'd9);
      check("stuck_word", {16'h0, sim_report[31:16]}, 32'h0000FFFF);
      check("stuck_success", {31'h0, sim_success}, 32'd0);
      force_cipo = 1'b0;

      // Hold asserted before frame 3 keeps csn high
      restart();
      wait_frames("run3", 3);
      force_hold = 1'b1;
      snap = csn_low;
      repeat (300) @(negedge refclk);
      check("hold_no_frame", 32'(csn_low - snap), 32'd0);
      check("hold_frames", {24'h0, sim_report[7:0]}, 32'd3);
      force_hold = 1'b0;
      wait_done("run3");
      check("run3_success", {31'h0, sim_success}, 32'd1);

      // Reset pulsed in the middle of frame 2
      restart();
      wait_frames("run4", 2);
      begin
         int n = 0;
         while (com_csn && n < 1000) begin
            @(negedge refclk);
            n++;
         end
         if (com_csn) check("run4_csn_timeout", 32'd0, 32'd1);
      end
      repeat (60) @(negedge refclk);
      rst = 1'b0;
      @(negedge refclk);
      check_reset("midframe");
      repeat (3) @(negedge refclk);
      rst = 1'b1;
      wait_done("run4");
      check("run4_success", {31'h0, sim_success}, 32'd1);
      check("run4_report", sim_report, {w7, 8'h00, 8'h09});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
